// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - Gray-to-binary step decoder with illegal-transition detection
module gray_decoder #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] gray_i,
   input  logic             clr_err_i,
   output logic [WIDTH-1:0] bin_o,
   output logic             valid_o,
   output logic             step_o,
   output logic             dir_o,
   output logic             err_o,
   output logic [7:0]       err_cnt_o
);

   typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_ERROR} state_t;

   state_t                              state_q, state_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
   logic [WIDTH-1:0]                    nb_conv;
   logic [WIDTH-1:0]                    nb_q;
   logic [WIDTH-1:0]                    bin_inc, bin_dec;
   logic [7:0]                          cnt_sat;
   logic                                illegal;

   logic [WIDTH-1:0] bin_d;
   logic             valid_d, step_d, dir_d, err_d;
   logic [7:0]       cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         nb_q   <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], gray_i};
         nb_q   <= nb_conv;
      end
   end

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      nb_conv = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nb_conv[i] = ^(sync_q[SYNC_STAGES-1] >> i);
      end
   end

   assign bin_inc = bin_o + WIDTH'(1);
   assign bin_dec = bin_o - WIDTH'(1);
   assign cnt_sat = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_o;
      valid_d = valid_o;
      step_d  = 1'b0;
      dir_d   = dir_o;
      err_d   = err_o;
      cnt_d   = err_cnt_o;
      illegal = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (en_i) begin
               bin_d   = nb_q;
               valid_d = 1'b1;
               state_d = ST_TRACK;
            end
         end
         ST_TRACK, ST_ERROR: begin
            if (en_i) begin
               if (nb_q == bin_inc) begin
                  bin_d  = nb_q;
                  step_d = 1'b1;
                  dir_d  = 1'b1;
               end else if (nb_q == bin_dec) begin
                  bin_d  = nb_q;
                  step_d = 1'b1;
                  dir_d  = 1'b0;
               end else if (nb_q != bin_o) begin
                  illegal = 1'b1;
                  bin_d   = nb_q;
                  err_d   = 1'b1;
                  cnt_d   = clr_err_i ? 8'd1 : cnt_sat;
                  state_d = ST_ERROR;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      // A coincident illegal transition takes priority over the clear.
      if (clr_err_i && !illegal) begin
         cnt_d = 8'd0;
         if (state_q == ST_ERROR) begin
            err_d   = 1'b0;
            state_d = ST_TRACK;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_INIT;
         bin_o     <= '0;
         valid_o   <= 1'b0;
         step_o    <= 1'b0;
         dir_o     <= 1'b1;
         err_o     <= 1'b0;
         err_cnt_o <= 8'd0;
      end else begin
         state_q   <= state_d;
         bin_o     <= bin_d;
         valid_o   <= valid_d;
         step_o    <= step_d;
         dir_o     <= dir_d;
         err_o     <= err_d;
         err_cnt_o <= cnt_d;
      end
   end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - Directed table-driven bench for gray_decoder
module tb_gray_decoder;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic [2:0] gray_i;
   logic       clr_err_i;
   logic [2:0] bin_o;
   logic       valid_o, step_o, dir_o, err_o;
   logic [7:0] err_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0] gray;
      logic [2:0] bin;
      logic       step;
      logic       dir;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs [14];

   gray_decoder #(.WIDTH(3), .SYNC_STAGES(2)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .gray_i    (gray_i),
      .clr_err_i (clr_err_i),
      .bin_o     (bin_o),
      .valid_o   (valid_o),
      .step_o    (step_o),
      .dir_o     (dir_o),
      .err_o     (err_o),
      .err_cnt_o (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " bin"},   bin_o,     0);
      chk({tag, " valid"}, valid_o,   0);
      chk({tag, " step"},  step_o,    0);
      chk({tag, " dir"},   dir_o,     1);
      chk({tag, " err"},   err_o,     0);
      chk({tag, " cnt"},   err_cnt_o, 0);
   endtask

   initial begin
      logic [2:0] prev_bin;
      logic       step_seen;

      vecs[0]  = '{3'b001, 3'd1, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[1]  = '{3'b011, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[2]  = '{3'b010, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[3]  = '{3'b110, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[4]  = '{3'b111, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[5]  = '{3'b101, 3'd6, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[6]  = '{3'b100, 3'd7, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[7]  = '{3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[8]  = '{3'b100, 3'd7, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{3'b100, 3'd7, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[11] = '{3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      vecs[12] = '{3'b011, 3'd2, 1'b0, 1'b1, 1'b1, 8'd1};
      vecs[13] = '{3'b010, 3'd3, 1'b1, 1'b1, 1'b1, 8'd1};

      rst_i = 1'b1; en_i = 1'b1; gray_i = 3'b000; clr_err_i = 1'b0;
      #2;
      chk_reset_vals("reset");
      #20;
      rst_i = 1'b0;
      tick();
      tick();
      chk("init valid", valid_o, 1);
      chk("init bin",   bin_o,   0);
      chk("init step",  step_o,  0);
      chk("init err",   err_o,   0);

      // Each code must appear exactly on the 4th edge after it is driven.
      prev_bin = 3'd0;
      for (int v = 0; v < 14; v++) begin
         gray_i = vecs[v].gray;
         tick(); tick(); tick();
         chk($sformatf("v%0d early bin", v),  bin_o,  prev_bin);
         chk($sformatf("v%0d early step", v), step_o, 0);
         tick();
         chk($sformatf("v%0d bin", v),  bin_o,     vecs[v].bin);
         chk($sformatf("v%0d step", v), step_o,    vecs[v].step);
         chk($sformatf("v%0d dir", v),  dir_o,     vecs[v].dir);
         chk($sformatf("v%0d err", v),  err_o,     vecs[v].err);
         chk($sformatf("v%0d cnt", v),  err_cnt_o, vecs[v].cnt);
         tick();
         chk($sformatf("v%0d step drop", v), step_o, 0);
         prev_bin = vecs[v].bin;
      end

      // Clear coincident with a second illegal jump (3 -> 6).
      gray_i = 3'b101;
      tick(); tick(); tick();
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      chk("coinc bin", bin_o,     6);
      chk("coinc err", err_o,     1);
      chk("coinc cnt", err_cnt_o, 1);
      tick();
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      chk("clr err", err_o,     0);
      chk("clr cnt", err_cnt_o, 0);

      // Saturation: alternate bin 2 / bin 0 every cycle, each one illegal.
      gray_i = 3'b000;
      tick(); tick(); tick(); tick();
      chk("sat first cnt", err_cnt_o, 1);
      for (int i = 0; i < 300; i++) begin
         gray_i = (i % 2 == 0) ? 3'b011 : 3'b000;
         tick();
      end
      tick(); tick(); tick(); tick();
      chk("sat cnt", err_cnt_o, 255);
      chk("sat err", err_o,     1);
      chk("sat bin", bin_o,     0);
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      chk("sat clr err", err_o,     0);
      chk("sat clr cnt", err_cnt_o, 0);

      // Disabled while the count advances two codes.
      en_i = 1'b0;
      step_seen = 1'b0;
      gray_i = 3'b001;
      for (int i = 0; i < 2; i++) begin tick(); step_seen |= step_o; end
      gray_i = 3'b011;
      for (int i = 0; i < 5; i++) begin tick(); step_seen |= step_o; end
      chk("hold bin",  bin_o,     0);
      chk("hold step", step_seen, 0);
      en_i = 1'b1;
      tick();
      chk("resume bin",  bin_o,     2);
      chk("resume err",  err_o,     1);
      chk("resume cnt",  err_cnt_o, 1);
      chk("resume step", step_o,    0);

      // Asynchronous reset between edges, mid-count.
      gray_i = 3'b010;
      tick(); tick();
      #2;
      rst_i = 1'b1;
      #1;
      chk_reset_vals("async rst");
      en_i = 1'b0;
      gray_i = 3'b110;
      tick(); tick();
      #2;
      rst_i = 1'b0;
      tick(); tick(); tick(); tick();
      chk("post rst valid", valid_o, 0);
      en_i = 1'b1;
      tick();
      chk("post rst bin",   bin_o,     4);
      chk("post rst valid", valid_o,   1);
      chk("post rst err",   err_o,     0);
      chk("post rst cnt",   err_cnt_o, 0);
      chk("post rst step",  step_o,    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
